// File: rtl/agc_shift_controller.sv
// Automatic gain control: saturating power-of-two gain on a sample stream,
// with the shift stepped by one after each window of accepted samples.
module agc_shift_controller #(
    parameter int WordLengthBits = 12,
    parameter int MaxShift       = 4,
    parameter int WindowLog2     = 8,
    parameter int LowPeak        = 2**(WordLengthBits-3),
    localparam int SW            = $clog2(MaxShift+1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [WordLengthBits-1:0] in,
    input  logic                             in_valid,
    output logic signed [WordLengthBits-1:0] out,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             enable,
    input  logic                             cfg_shift_load,
    input  logic [SW-1:0]                    cfg_shift,
    output logic [SW-1:0]                    shift,
    output logic                             shift_changed
);
    localparam int W = WordLengthBits;
    localparam logic signed [W-1:0] OutMax = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] OutMin = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]        LowThr = W'(LowPeak);
    localparam logic [SW-1:0]       ShMax  = SW'(MaxShift);

    typedef enum logic [1:0] {DISABLED, MEASURE, DECIDE} state_t;

    state_t                state;
    logic [WindowLog2-1:0] cnt;
    logic [W-1:0]          peak;
    logic                  sat_flag;

    logic                  sat_now;
    logic signed [W-1:0]   out_next;
    logic [W-1:0]          mag;
    logic [W-1:0]          peak_next;
    logic                  sat_next;
    logic [WindowLog2-1:0] cnt_cur;
    logic                  win_end;
    logic [SW-1:0]         load_val;

    // Saturate when any of the bits shifted into the sign position differ from the sign.
    always_comb begin
        sat_now = 1'b0;
        for (int i = 0; i < MaxShift; i++) begin
            if (i < int'(shift) && in[W-2-i] != in[W-1])
                sat_now = 1'b1;
        end
    end

    always_comb begin
        if (sat_now)
            out_next = in[W-1] ? OutMin : OutMax;
        else
            out_next = in <<< shift;
        // Magnitude is unsigned, so |OutMin| = 2**(W-1) fits without wrapping.
        mag       = out_next[W-1] ? (~out_next + 1'b1) : out_next;
        peak_next = (mag > peak) ? mag : peak;
        sat_next  = sat_flag | sat_now;
        // A freshly enabled controller always starts its window from zero.
        cnt_cur   = (state == DISABLED) ? '0 : cnt;
        win_end   = in_valid && (cnt_cur == {WindowLog2{1'b1}});
        load_val  = (cfg_shift > ShMax) ? ShMax : cfg_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out           <= '0;
            out_valid     <= 1'b0;
            shift         <= '0;
            shift_changed <= 1'b0;
            state         <= DISABLED;
            cnt           <= '0;
            peak          <= '0;
            sat_flag      <= 1'b0;
        end else begin
            shift_changed <= 1'b0;

            if (in_valid) begin
                out       <= out_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (!enable) begin
                state    <= DISABLED;
                cnt      <= '0;
                peak     <= '0;
                sat_flag <= 1'b0;
            end else if (win_end) begin
                // Decision includes the closing sample; the new shift shows during DECIDE.
                state    <= DECIDE;
                cnt      <= '0;
                peak     <= '0;
                sat_flag <= 1'b0;
                if (sat_next && shift != '0) begin
                    shift         <= shift - 1'b1;
                    shift_changed <= 1'b1;
                end else if (!sat_next && peak_next < LowThr && shift < ShMax) begin
                    shift         <= shift + 1'b1;
                    shift_changed <= 1'b1;
                end
            end else if (in_valid) begin
                state    <= MEASURE;
                cnt      <= cnt_cur + 1'b1;
                peak     <= peak_next;
                sat_flag <= sat_next;
            end else begin
                state <= MEASURE;
                cnt   <= cnt_cur;
            end

            // Forced load overrides any same-cycle decision and restarts the window.
            if (cfg_shift_load) begin
                shift         <= load_val;
                shift_changed <= 1'b0;
                cnt           <= '0;
                peak          <= '0;
                sat_flag      <= 1'b0;
                if (enable)
                    state <= MEASURE;
            end
        end
    end
endmodule

// File: tb/tb_agc_shift_controller.sv
// Directed bench for agc_shift_controller with a 16-sample window.
module tb_agc_shift_controller;
    localparam int W  = 12;
    localparam int MS = 4;
    localparam int WL = 4;
    localparam int LP = 512;
    localparam int SW = $clog2(MS+1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [W-1:0]  din;
    logic                 in_valid;
    logic signed [W-1:0]  dout;
    logic                 out_valid;
    logic                 out_ready;
    logic                 enable;
    logic                 cfg_shift_load;
    logic [SW-1:0]        cfg_shift;
    logic [SW-1:0]        shift;
    logic                 shift_changed;

    int checks = 0;
    int errors = 0;

    agc_shift_controller #(
        .WordLengthBits(W), .MaxShift(MS), .WindowLog2(WL), .LowPeak(LP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid),
        .out(dout), .out_valid(out_valid), .out_ready(out_ready),
        .enable(enable), .cfg_shift_load(cfg_shift_load), .cfg_shift(cfg_shift),
        .shift(shift), .shift_changed(shift_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample, let one edge pass, return at the following negedge.
    task automatic send(input int v);
        din      = W'(v);
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    // n samples at a fixed shift; the window decision is checked after the last one.
    task automatic window(input string tag, input int vp, input int vn, input int ep,
                          input int en, input int n, input bit alt,
                          input int exp_shift, input int exp_pulse);
        int  pulses;
        bit  neg;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            neg = alt && i[0];
            send(neg ? vn : vp);
            chk({tag, "_out"}, int'($signed(dout)), neg ? en : ep);
            if (i < n-1) pulses += int'(shift_changed);
        end
        in_valid = 1'b0;
        chk({tag, "_early_pulse"}, pulses, 0);
        chk({tag, "_shift"}, int'(shift), exp_shift);
        chk({tag, "_pulse"}, int'(shift_changed), exp_pulse);
    endtask

    initial begin
        din = '0; in_valid = 1'b0; out_ready = 1'b0; enable = 1'b0;
        cfg_shift_load = 1'b0; cfg_shift = '0;
        #1;
        chk("rst_out", int'($signed(dout)), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_shift", int'(shift), 0);
        chk("rst_pulse", int'(shift_changed), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Gain climbs while the window peak stays under 512.
        window("w0", 100, 0, 100, 0, 16, 1'b0, 1, 1);
        send(100);
        in_valid = 1'b0;
        chk("w1_first_out", int'($signed(dout)), 200);
        chk("w1_first_pulse", int'(shift_changed), 0);
        window("w1", 100, 0, 200, 0, 15, 1'b0, 2, 1);
        window("w2", 100, 0, 400, 0, 16, 1'b0, 3, 1);
        window("w3", 100, 0, 800, 0, 16, 1'b0, 3, 0);

        // Saturating both polarities steps the gain down.
        window("sat", 300, -300, 2047, -2048, 16, 1'b1, 2, 1);

        // Output holds under backpressure, drains once consumed.
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_out", int'($signed(dout)), -2048);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_valid", int'(out_valid), 0);

        // Forced load on the closing sample wins over the pending raise.
        window("pre_load", 100, 0, 400, 0, 15, 1'b0, 2, 0);
        cfg_shift = 3'd7;
        cfg_shift_load = 1'b1;
        send(100);
        cfg_shift_load = 1'b0;
        in_valid = 1'b0;
        chk("load_out", int'($signed(dout)), 400);
        chk("load_shift", int'(shift), 4);
        chk("load_pulse", int'(shift_changed), 0);
        window("post_load", 300, 0, 2047, 0, 16, 1'b0, 3, 1);

        // Disabled: no adaptation, load still honoured, fresh window on re-enable.
        enable = 1'b0;
        window("dis", 10, 0, 80, 0, 20, 1'b0, 3, 0);
        cfg_shift = 3'd1;
        cfg_shift_load = 1'b1;
        @(negedge clk);
        cfg_shift_load = 1'b0;
        chk("dis_load_shift", int'(shift), 1);
        chk("dis_load_pulse", int'(shift_changed), 0);
        enable = 1'b1;
        window("reen", 100, 0, 200, 0, 16, 1'b0, 2, 1);

        // Asynchronous reset mid-window, checked before the next rising edge.
        for (int i = 0; i < 5; i++) send(100);
        chk("pre_rst_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", int'($signed(dout)), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_shift", int'(shift), 0);
        chk("arst_pulse", int'(shift_changed), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
